// File: rtl/ysyx_22040127_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_ifu_pkg
// Brief    : Shared constants and helpers for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040127_ifu_pkg;

  // Width of the {inst, pc} bundle handed to decode
  localparam int          IF_TO_ID_WIDTH = 64;

  // Default first fetch address after reset release
  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;

  // Pick the 32-bit instruction out of an aligned doubleword; the caller
  // passes pc[2], which says whether the instruction sits in the upper word
  function automatic logic [31:0] ifu_sel_word(input logic [63:0] dword,
                                               input logic        upper);
    return upper ? dword[63:32] : dword[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_ifu_fifo
// Brief    : Small synchronous FIFO with push/pop/flush and occupancy count.
//            Flush has priority over a coincident push or pop.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040127_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_rd_ptr;
  logic [C_AW-1:0]  r_wr_ptr;
  logic [C_CW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == C_CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Guard against writing a full buffer or reading an empty one
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; contents need no reset because the count qualifies them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush returns to the empty state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CW'(1);
        2'b01:   r_count <= r_count - C_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_ifu
// Brief    : Instruction-fetch stage. Issues one outstanding PC request at a
//            time, buffers returned instructions and hands {inst, pc} to ID.
//            Branch redirects flush the buffer and squash in-flight fetches.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040127_ifu
  import ysyx_22040127_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
  output logic [31:0]               if_pc,
  input  logic                      id_branch_taken,
  input  logic [31:0]               id_branch_result,
  output logic                      imem_req_valid,
  input  logic                      imem_req_ready,
  output logic [31:0]               imem_req_addr,
  input  logic                      imem_resp_valid,
  input  logic [63:0]               imem_resp_data
);

  localparam int         C_CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] C_ST_BOOT = 2'd0;
  localparam logic [1:0] C_ST_REQ  = 2'd1;
  localparam logic [1:0] C_ST_WAIT = 2'd2;

  logic [1:0]                r_state;
  logic [31:0]               r_fetch_pc;  // next address to request
  logic [31:0]               r_req_pc;    // address of the in-flight request
  logic [31:0]               r_hold_pc;   // address of a stalled, squashed request
  logic                      r_hold;      // stalled request must be dropped on accept
  logic                      r_discard;   // in-flight response must be dropped

  logic [C_CW-1:0]           w_count;
  logic                      w_empty;
  logic                      w_full;
  logic [IF_TO_ID_WIDTH-1:0] w_head;
  logic                      w_credit;
  logic                      w_req_fire;
  logic                      w_push;
  logic                      w_pop;
  logic [31:0]               w_target;
  logic [IF_TO_ID_WIDTH-1:0] w_push_data;
  logic                      w_unused;

  // Only one request may be outstanding, so a free slot is enough credit
  assign w_credit       = (w_count < C_CW'(FIFO_DEPTH));
  assign imem_req_valid = (r_state == C_ST_REQ) && w_credit;
  // A stalled request keeps its address even after a redirect
  assign imem_req_addr  = r_hold ? r_hold_pc : r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_target       = {id_branch_result[31:2], 2'b00};
  assign w_unused       = &{1'b0, id_branch_result[1:0], w_full};

  // A redirect in the same cycle flushes, so the response is not kept
  assign w_push         = (r_state == C_ST_WAIT) && imem_resp_valid &&
                          !r_discard && !id_branch_taken;
  assign w_push_data    = {ifu_sel_word(imem_resp_data, r_req_pc[2]), r_req_pc};
  assign w_pop          = if_to_id_valid && id_allowin;

  ysyx_22040127_ifu_fifo #(
    .WIDTH (IF_TO_ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (id_branch_taken),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign if_to_id_valid = !w_empty;
  assign if_to_id_bus   = w_head;
  assign if_pc          = w_empty ? RESET_PC : w_head[31:0];

  // Fetch FSM: BOOT for one cycle, then alternate REQ / WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= C_ST_BOOT;
      r_req_pc <= RESET_PC;
    end else begin
      case (r_state)
        C_ST_BOOT: r_state <= C_ST_REQ;
        C_ST_REQ: begin
          if (w_req_fire) begin
            r_state  <= C_ST_WAIT;
            r_req_pc <= imem_req_addr;
          end
        end
        C_ST_WAIT: begin
          if (imem_resp_valid) begin
            r_state <= C_ST_REQ;
          end
        end
        default: r_state <= C_ST_BOOT;
      endcase
    end
  end

  // Next fetch address: redirect target wins, otherwise advance on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (id_branch_taken) begin
      r_fetch_pc <= w_target;
    end else if (w_req_fire && !r_hold) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Remember a stalled request that a redirect has made stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold    <= 1'b0;
      r_hold_pc <= RESET_PC;
    end else if (w_req_fire) begin
      r_hold    <= 1'b0;
    end else if (id_branch_taken && imem_req_valid) begin
      r_hold    <= 1'b1;
      r_hold_pc <= imem_req_addr;
    end
  end

  // Mark the in-flight response for dropping when a redirect overtakes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        C_ST_REQ: begin
          if (w_req_fire && (id_branch_taken || r_hold)) begin
            r_discard <= 1'b1;
          end
        end
        C_ST_WAIT: begin
          if (imem_resp_valid) begin
            r_discard <= 1'b0;
          end else if (id_branch_taken) begin
            r_discard <= 1'b1;
          end
        end
        default: r_discard <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040127_ifu
// Brief    : Self-checking bench for the instruction-fetch stage with a
//            transaction-level reference model and a latency-randomised
//            instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;
  logic [31:0] if_pc;
  logic        id_branch_taken;
  logic [31:0] id_branch_result;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;

  always #5 clk = ~clk;

  ysyx_22040127_ifu #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .id_allowin       (id_allowin),
    .if_to_id_valid   (if_to_id_valid),
    .if_to_id_bus     (if_to_id_bus),
    .if_pc            (if_pc),
    .id_branch_taken  (id_branch_taken),
    .id_branch_result (id_branch_result),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state: what ID should see, and what memory owes us
  logic [63:0] exp_q [$];
  logic [63:0] pop_q [$];
  logic [31:0] acc_q [$];
  logic [31:0] next_pc;
  bit          stale;
  bit          out_v;
  bit          out_live;
  logic [31:0] out_addr;
  int          out_due;
  int          cyc = 0;
  bit          hold_prev;
  logic [31:0] hold_addr;
  bit          last_req_v;
  logic [31:0] last_req_addr;
  int          n_pop = 0;

  // Stimulus knobs
  int          allow_pct;
  int          ready_pct;
  int          br_pct;
  int unsigned dly_min;
  int unsigned dly_max;
  bit          force_br;
  logic [31:0] force_tgt;
  bit          stray_resp;
  logic [31:0] t4_held;

  // Memory image: every word address holds a distinct, address-derived word
  function automatic logic [31:0] instw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_pc   = RESET_PC;
    stale     = 1'b0;
    out_v     = 1'b0;
    out_live  = 1'b0;
    hold_prev = 1'b0;
  endtask

  // One clock: drive, sample just before the edge, update model, compare
  task automatic cycle();
    bit          s_req_v, s_ready, s_br, s_allow, s_resp, fire, pop;
    logic [31:0] s_addr, s_tgt;
    id_allowin       = (int'($urandom_range(99)) < allow_pct);
    imem_req_ready   = (int'($urandom_range(99)) < ready_pct);
    id_branch_taken  = force_br || (int'($urandom_range(99)) < br_pct);
    id_branch_result = force_br ? force_tgt : (32'h8000_0000 | ($urandom & 32'h0000_0FFF));
    s_resp           = out_v && (cyc >= out_due);
    imem_resp_valid  = s_resp || stray_resp;
    imem_resp_data   = s_resp ? {instw({out_addr[31:3], 3'b100}), instw({out_addr[31:3], 3'b000})}
                              : {$urandom, $urandom};
    #3;
    s_req_v = imem_req_valid;
    s_addr  = imem_req_addr;
    s_ready = imem_req_ready;
    s_br    = id_branch_taken;
    s_tgt   = id_branch_result;
    s_allow = id_allowin;
    if (out_v)     chk("single_outstanding", 64'(s_req_v), 64'd0);
    if (s_req_v)   chk("credit", 64'(exp_q.size() < DEPTH), 64'd1);
    if (hold_prev) begin
      chk("req_held_valid", 64'(s_req_v), 64'd1);
      chk("req_held_addr", 64'(s_addr), 64'(hold_addr));
    end
    fire = s_req_v && s_ready;
    pop  = (exp_q.size() > 0) && s_allow;
    @(posedge clk);
    #1;
    cyc++;
    if (s_br) begin
      exp_q.delete();
    end else begin
      if (pop) begin
        pop_q.push_back(exp_q.pop_front());
        n_pop++;
      end
      if (s_resp && out_live) exp_q.push_back({instw(out_addr), out_addr});
    end
    if (s_resp) out_v = 1'b0;
    if (fire) begin
      acc_q.push_back(s_addr);
      if (!stale) begin
        chk("req_addr", 64'(s_addr), 64'(next_pc));
        next_pc = next_pc + 32'd4;
      end
      out_v    = 1'b1;
      out_addr = s_addr;
      out_live = !stale && !s_br;
      out_due  = cyc + int'($urandom_range(dly_max, dly_min));
      stale    = 1'b0;
    end
    if (s_br) begin
      out_live = 1'b0;
      if (s_req_v && !s_ready) stale = 1'b1;
      next_pc = {s_tgt[31:2], 2'b00};
    end
    hold_prev     = s_req_v && !s_ready;
    hold_addr     = s_addr;
    last_req_v    = s_req_v;
    last_req_addr = s_addr;
    chk("id_valid", 64'(if_to_id_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("id_bus", if_to_id_bus, exp_q[0]);
      chk("if_pc", 64'(if_pc), 64'(exp_q[0][31:0]));
    end else begin
      chk("if_pc_empty", 64'(if_pc), 64'(RESET_PC));
    end
  endtask

  initial begin
    rst = 1'b0; id_allowin = 1'b0; id_branch_taken = 1'b0; id_branch_result = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    force_br = 1'b0; force_tgt = '0; stray_resp = 1'b0;
    allow_pct = 100; ready_pct = 100; br_pct = 0; dly_min = 0; dly_max = 0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_id_valid", 64'(if_to_id_valid), 64'd0);
    chk("rst_if_pc", 64'(if_pc), 64'(RESET_PC));

    // Test 1: sequential fetch, memory answers in the next cycle
    rst = 1'b1;
    cycle();
    chk("boot_no_req", 64'(last_req_v), 64'd0);
    acc_q.delete(); pop_q.delete();
    repeat (10) cycle();
    chk("t1_acc0", 64'(acc_q[0]), 64'(RESET_PC));
    chk("t1_acc1", 64'(acc_q[1]), 64'(RESET_PC + 32'd4));
    chk("t1_first_bus", pop_q[0], {instw(RESET_PC), RESET_PC});
    chk("t1_upper_word", 64'(pop_q[1][63:32]), 64'(instw(RESET_PC + 32'd4)));

    // Test 2: ID stalls, buffer fills and requests stop
    allow_pct = 0;
    repeat (10) cycle();
    #1;
    chk("t2_req_stalled", 64'(imem_req_valid), 64'd0);
    chk("t2_id_valid", 64'(if_to_id_valid), 64'd1);
    allow_pct = 100; ready_pct = 0;
    cycle();
    chk("t2_after_pop1", 64'(if_to_id_valid), 64'd1);
    cycle();
    chk("t2_after_pop2", 64'(if_to_id_valid), 64'd0);
    ready_pct = 100;
    repeat (6) cycle();

    // Test 3: redirect while waiting for a response
    dly_min = 2; dly_max = 2;
    for (int i = 0; i < 20 && !out_v; i++) cycle();
    chk("t3_reach_wait", 64'(out_v), 64'd1);
    force_br = 1'b1; force_tgt = 32'h8000_0103;
    cycle();
    force_br = 1'b0;
    acc_q.delete(); pop_q.delete();
    repeat (12) cycle();
    chk("t3_next_req", 64'(acc_q[0]), 64'h8000_0100);
    chk("t3_first_id_pc", 64'(pop_q[0][31:0]), 64'h8000_0100);

    // Test 4: redirect while a request is stalled by memory
    dly_min = 1; dly_max = 1; ready_pct = 0;
    last_req_v = 1'b0;
    for (int i = 0; i < 20 && !last_req_v; i++) cycle();
    chk("t4_reach_stall", 64'(last_req_v), 64'd1);
    t4_held  = last_req_addr;
    force_br = 1'b1; force_tgt = 32'h8000_0200;
    cycle();
    force_br = 1'b0;
    acc_q.delete(); pop_q.delete();
    repeat (2) cycle();
    ready_pct = 100;
    repeat (14) cycle();
    chk("t4_held_accept", 64'(acc_q[0]), 64'(t4_held));
    chk("t4_target_req", 64'(acc_q[1]), 64'h8000_0200);
    chk("t4_first_id_pc", 64'(pop_q[0][31:0]), 64'h8000_0200);

    // Test 5: redirect coincident with pop while the buffer is full
    dly_min = 0; dly_max = 0; allow_pct = 0;
    for (int i = 0; i < 20 && exp_q.size() < DEPTH; i++) cycle();
    chk("t5_reach_full", 64'(exp_q.size() == DEPTH), 64'd1);
    force_br = 1'b1; force_tgt = 32'h8000_0300; allow_pct = 100;
    cycle();
    force_br = 1'b0;
    chk("t5_flushed", 64'(if_to_id_valid), 64'd0);
    pop_q.delete();
    repeat (8) cycle();
    chk("t5_first_id_pc", 64'(pop_q[0][31:0]), 64'h8000_0300);

    // Random traffic
    allow_pct = 60; ready_pct = 70; br_pct = 6; dly_min = 0; dly_max = 3;
    repeat (1500) cycle();

    // Test 6: reset asserted mid-WAIT with stray responses around it
    br_pct = 0; dly_min = 3; dly_max = 3;
    for (int i = 0; i < 20 && !out_v; i++) cycle();
    chk("t6_reach_wait", 64'(out_v), 64'd1);
    rst = 1'b0; imem_resp_valid = 1'b1;
    #1;
    chk("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("t6_rst_id_valid", 64'(if_to_id_valid), 64'd0);
    chk("t6_rst_if_pc", 64'(if_pc), 64'(RESET_PC));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    stray_resp = 1'b1;
    acc_q.delete();
    cycle();
    stray_resp = 1'b0;
    chk("t6_boot_no_req", 64'(last_req_v), 64'd0);
    dly_min = 0; dly_max = 0;
    repeat (6) cycle();
    chk("t6_first_req", 64'(acc_q[0]), 64'(RESET_PC));

    // More random traffic after the mid-run reset
    allow_pct = 75; ready_pct = 50; br_pct = 4; dly_min = 0; dly_max = 2;
    repeat (500) cycle();
    chk("progress", 64'(n_pop > 100), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
